relu_backprop_gate: RTL and testbench



---
 rtl/relu_bp_pkg.sv | 24 ++
 rtl/relu_mask_buffer.sv | 33 +++
 rtl/relu_backprop_gate.sv | 131 +++++++++++++
 tb/tb_relu_backprop_gate.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/relu_bp_pkg.sv
// Shared constants, state type and index helper
// for the layer-2 ReLU backward gate.
package relu_bp_pkg;

  localparam int CHANNELS = 2;
  localparam int HEIGHT   = 10;
  localparam int WIDTH    = 10;
  localparam int N_ELEM   = CHANNELS * HEIGHT * WIDTH;
  localparam int IDX_W    = $clog2(N_ELEM);

  typedef enum logic {
    ST_CAPTURE = 1'b0,
    ST_GATE    = 1'b1
  } state_e;

  function automatic logic [IDX_W-1:0] flat_index(
    input int c,
    input int i,
    input int j
  );
    return IDX_W'(c * HEIGHT * WIDTH + i * WIDTH + j);
  endfunction

endpackage

// File: rtl/relu_mask_buffer.sv
// One pass/block bit per feature-map element:
// single write port, combinational read port.
module relu_mask_buffer #(
  parameter int N  = 200,
  parameter int IW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [IW-1:0] widx,
  input  logic          wbit,
  input  logic [IW-1:0] ridx,
  output logic          rbit
);

  logic [N-1:0] mask_q;
  logic [N-1:0] mask_d;

  // Next mask: overwrite one bit on a write.
  always_comb begin
    mask_d = mask_q;
    if (we) mask_d[widx] = wbit;
  end

  // Mask storage, cleared on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mask_q <= '0;
    else        mask_q <= mask_d;
  end

  assign rbit = mask_q[ridx];

endmodule

// File: rtl/relu_backprop_gate.sv
// ReLU backward gate: capture forward sign mask,
// then pass or zero the upstream gradient.
module relu_backprop_gate
  import relu_bp_pkg::*;
#(
  parameter int BITWIDTH = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic                fwd_valid,
  output logic                fwd_ready,
  input  logic [BITWIDTH-1:0] fwd_data,
  input  logic                grad_in_valid,
  output logic                grad_in_ready,
  input  logic [BITWIDTH-1:0] grad_in_data,
  output logic                grad_out_valid,
  input  logic                grad_out_ready,
  output logic [BITWIDTH-1:0] grad_out_data,
  output logic                frame_done,
  output logic                phase
);

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                ov_q, ov_d;
  logic [BITWIDTH-1:0] od_q, od_d;
  logic                fd_q, fd_d;

  logic fwd_acc;
  logic grad_acc;
  logic out_acc;
  logic last_idx;
  logic mask_wbit;
  logic mask_rbit;
  logic unused_fwd;

  assign fwd_ready = (state_q == ST_CAPTURE);
  assign grad_in_ready = (state_q == ST_GATE)
                      && (!ov_q || grad_out_ready);

  // flush wins over any handshake in the same cycle
  assign fwd_acc  = fwd_valid && fwd_ready && !flush;
  assign grad_acc = grad_in_valid && grad_in_ready
                 && !flush;
  assign out_acc  = ov_q && grad_out_ready;
  assign last_idx = (idx_q == IDX_W'(N_ELEM - 1));

  // sign bit clear (incl. zero) means the element passed
  assign mask_wbit  = ~fwd_data[BITWIDTH-1];
  assign unused_fwd = ^fwd_data[BITWIDTH-2:0];

  relu_mask_buffer #(
    .N  (N_ELEM),
    .IW (IDX_W)
  ) u_mask (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (fwd_acc),
    .widx  (idx_q),
    .wbit  (mask_wbit),
    .ridx  (idx_q),
    .rbit  (mask_rbit)
  );

  // Phase FSM, element index and output register.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ov_d    = ov_q;
    od_d    = od_q;
    fd_d    = 1'b0;
    if (flush) begin
      state_d = ST_CAPTURE;
      idx_d   = '0;
      ov_d    = 1'b0;
    end else begin
      if (out_acc) ov_d = 1'b0;
      unique case (state_q)
        ST_CAPTURE: begin
          if (fwd_acc) begin
            if (last_idx) begin
              idx_d   = '0;
              state_d = ST_GATE;
            end else begin
              idx_d = idx_q + IDX_W'(1);
            end
          end
        end
        ST_GATE: begin
          if (grad_acc) begin
            od_d = mask_rbit ? grad_in_data
                             : '0;
            ov_d = 1'b1;
            if (last_idx) begin
              idx_d   = '0;
              state_d = ST_CAPTURE;
              fd_d    = 1'b1;
            end else begin
              idx_d = idx_q + IDX_W'(1);
            end
          end
        end
        default: state_d = ST_CAPTURE;
      endcase
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_CAPTURE;
      idx_q   <= '0;
      ov_q    <= 1'b0;
      od_q    <= '0;
      fd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ov_q    <= ov_d;
      od_q    <= od_d;
      fd_q    <= fd_d;
    end
  end

  assign grad_out_valid = ov_q;
  assign grad_out_data  = od_q;
  assign frame_done     = fd_q;
  assign phase          = (state_q == ST_GATE);

endmodule

// File: tb/tb_relu_backprop_gate.sv
// Scoreboard bench for relu_backprop_gate with a
// plain-arithmetic ReLU backward reference model.
module tb_relu_backprop_gate;

  localparam int BW = 32;
  localparam int N  = 200;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic          fwd_valid = 1'b0;
  logic          fwd_ready;
  logic [BW-1:0] fwd_data = '0;
  logic          grad_in_valid = 1'b0;
  logic          grad_in_ready;
  logic [BW-1:0] grad_in_data = '0;
  logic          grad_out_valid;
  logic          grad_out_ready = 1'b1;
  logic [BW-1:0] grad_out_data;
  logic          frame_done;
  logic          phase;

  relu_backprop_gate #(.BITWIDTH(BW)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .flush          (flush),
    .fwd_valid      (fwd_valid),
    .fwd_ready      (fwd_ready),
    .fwd_data       (fwd_data),
    .grad_in_valid  (grad_in_valid),
    .grad_in_ready  (grad_in_ready),
    .grad_in_data   (grad_in_data),
    .grad_out_valid (grad_out_valid),
    .grad_out_ready (grad_out_ready),
    .grad_out_data  (grad_out_data),
    .frame_done     (frame_done),
    .phase          (phase)
  );

  always #5 clk = ~clk;

  int            n_cmp = 0;
  int            n_bad = 0;
  logic [BW-1:0] exp_q[$];
  bit            mask_m[N];
  logic [BW-1:0] fv[N];
  logic [BW-1:0] gv[N];
  int            rdy_mode = 0;
  int            cyc = 0;
  int            fd_cnt = 0;
  int            out_cnt = 0;
  bit            hold_v = 0;
  logic [BW-1:0] hold_d = '0;
  logic [3:0]    pat = 4'b1001;

  task automatic chk(input string nm,
                     input logic [BW-1:0] act,
                     input logic [BW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h",
               nm, act, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       grad_out_ready = 1'b1;
      1:       grad_out_ready = pat[cyc % 4];
      default: grad_out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor: pop and compare every output handshake.
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_v = 0;
    end else begin
      if (frame_done) fd_cnt++;
      if (hold_v) begin
        chk("stall_valid", 32'(grad_out_valid), 32'd1);
        chk("stall_data", grad_out_data, hold_d);
      end
      if (grad_out_valid && !grad_out_ready) begin
        chk("stall_in_ready", 32'(grad_in_ready), 32'd0);
        hold_v = 1;
        hold_d = grad_out_data;
      end else begin
        hold_v = 0;
      end
      if (grad_out_valid && grad_out_ready) begin
        out_cnt++;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL grad_out_extra: got %h expected none",
                   grad_out_data);
        end else begin
          chk("grad_out", grad_out_data, exp_q.pop_front());
        end
      end
    end
  end

  task automatic send_fwd(input logic [BW-1:0] d,
                          input int k);
    int t = 0;
    fwd_valid = 1'b1;
    fwd_data  = d;
    do begin
      @(negedge clk);
      t++;
    end while (!fwd_ready && t < 50);
    if (!fwd_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL fwd_timeout: got ready 0 expected 1");
    end else begin
      mask_m[k] = ($signed(d) >= 0);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_grad(input logic [BW-1:0] g,
                           input int k);
    int t = 0;
    grad_in_valid = 1'b1;
    grad_in_data  = g;
    do begin
      @(negedge clk);
      t++;
    end while (!grad_in_ready && t < 50);
    if (!grad_in_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL grad_timeout: got ready 0 expected 1");
    end else begin
      exp_q.push_back(mask_m[k] ? g : '0);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic capture(input int n);
    for (int k = 0; k < n; k++) send_fwd(fv[k], k);
    fwd_valid = 1'b0;
  endtask

  task automatic gate(input int n);
    for (int k = 0; k < n; k++) send_grad(gv[k], k);
    grad_in_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while ((exp_q.size() != 0 || grad_out_valid)
           && t < 200) begin
      @(posedge clk);
      #1;
      t++;
    end
    @(posedge clk);
    #1;
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic full_frame(input string nm);
    int f0;
    int o0;
    capture(N);
    chk({nm, "_phase_gate"}, 32'(phase), 32'd1);
    f0 = fd_cnt;
    o0 = out_cnt;
    gate(N);
    drain();
    chk({nm, "_frame_done"}, 32'(fd_cnt - f0), 32'd1);
    chk({nm, "_out_count"}, 32'(out_cnt - o0), 32'(N));
    chk({nm, "_phase_cap"}, 32'(phase), 32'd0);
  endtask

  task automatic rand_vals();
    for (int k = 0; k < N; k++) begin
      case ($urandom_range(0, 3))
        0:       fv[k] = '0;
        default: fv[k] = $urandom;
      endcase
      gv[k] = $urandom;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int c0;
    int f0;
    #2;
    chk("rst_fwd_ready", 32'(fwd_ready), 32'd1);
    chk("rst_grad_in_ready", 32'(grad_in_ready), 32'd0);
    chk("rst_out_valid", 32'(grad_out_valid), 32'd0);
    chk("rst_out_data", grad_out_data, 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_phase", 32'(phase), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // alternating-sign ramp, constant gradient 5
    for (int k = 0; k < N; k++) begin
      fv[k] = (k % 2) ? 32'(-k) : 32'(k);
      gv[k] = 32'd5;
    end
    capture(N);
    chk("t1_phase_gate", 32'(phase), 32'd1);
    f0 = fd_cnt;
    c0 = cyc;
    gate(N);
    chk("t1_throughput", 32'(cyc - c0), 32'(N));
    drain();
    chk("t1_frame_done", 32'(fd_cnt - f0), 32'd1);
    chk("t1_phase_cap", 32'(phase), 32'd0);

    // most-negative vs zero boundary
    rand_vals();
    fv[0] = 32'h8000_0000;
    fv[1] = 32'h0000_0000;
    for (int k = 0; k < N; k++) gv[k] = 32'h7FFF_FFFF;
    full_frame("t2");

    // output stalls with ready pattern 1,0,0,1
    rand_vals();
    rdy_mode = 1;
    full_frame("t3");

    // wrong-phase traffic is ignored
    rand_vals();
    rdy_mode = 2;
    grad_in_valid = 1'b1;
    grad_in_data  = 32'hDEAD_BEEF;
    for (int t = 0; t < 4; t++) begin
      @(negedge clk);
      chk("cap_grad_in_ready", 32'(grad_in_ready), 32'd0);
      chk("cap_phase", 32'(phase), 32'd0);
    end
    @(posedge clk);
    #1;
    grad_in_valid = 1'b0;
    capture(N);
    fwd_valid = 1'b1;
    fwd_data  = 32'hFFFF_FFFF;
    for (int t = 0; t < 4; t++) begin
      @(negedge clk);
      chk("gate_fwd_ready", 32'(fwd_ready), 32'd0);
      chk("gate_phase", 32'(phase), 32'd1);
    end
    @(posedge clk);
    #1;
    fwd_valid = 1'b0;
    gate(N);
    drain();
    chk("t4_phase_cap", 32'(phase), 32'd0);

    // flush during capture at idx 57
    rdy_mode = 0;
    rand_vals();
    capture(57);
    fwd_valid = 1'b1;
    fwd_data  = 32'h8000_0001;
    flush     = 1'b1;
    @(posedge clk);
    #1;
    flush     = 1'b0;
    fwd_valid = 1'b0;
    chk("flush_phase", 32'(phase), 32'd0);
    chk("flush_out_valid", 32'(grad_out_valid), 32'd0);
    rand_vals();
    full_frame("t5");

    // async reset mid-gate at idx 120
    rdy_mode = 2;
    rand_vals();
    capture(N);
    gate(120);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 32'(grad_out_valid), 32'd0);
    chk("mid_rst_out_data", grad_out_data, 32'd0);
    chk("mid_rst_phase", 32'(phase), 32'd0);
    chk("mid_rst_fwd_ready", 32'(fwd_ready), 32'd1);
    chk("mid_rst_grad_in_ready", 32'(grad_in_ready), 32'd0);
    chk("mid_rst_frame_done", 32'(frame_done), 32'd0);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    rand_vals();
    full_frame("t6");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
